dispatch_ctrl: RTL and testbench

- Sits between the decode stage and the out-of-order backend.
- Buffers decoded instructions in a 2-entry skid FIFO, so that `ready_in` depends only on registered state.
- Steers the head instruction to one of N_RS reservation stations by its `fu` field.
- Allocates a ROB entry and, when the instruction writes a register, a physical register; dispatch happens only when every needed resource is available in the same cycle.

---
 rtl/dispatch_ctrl_pkg.sv | 26 ++
 rtl/dispatch_ctrl_skid_fifo2.sv | 47 ++++
 rtl/dispatch_ctrl.sv | 93 +++++++++
 tb/tb_dispatch_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and encodings for the dispatch stage: decoded instruction record,
// opcodes that never write a destination register, and functional-unit steering codes.
package dispatch_ctrl_pkg;

   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] FU_ALU    = 2'd0;
   localparam logic [1:0] FU_BRANCH = 2'd1;
   localparam logic [1:0] FU_LSU    = 2'd2;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [1:0]  fu;
      logic [11:0] imm;
   } decode_data;

   // x0 is hardwired and stores/branches have no destination, so none of them take a preg.
   function automatic logic writes_rd(decode_data d);
      return (d.rd != 5'd0) && (d.opcode != OP_STORE) && (d.opcode != OP_BRANCH);
   endfunction

endpackage

// File: rtl/dispatch_ctrl_skid_fifo2.sv
// Two-entry skid FIFO, generic over element type. Caller guarantees push only when
// count != 2 and pop only when count != 0; flush empties it on the next edge.
module skid_fifo2 #(
   parameter type T = logic
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  T           push_data,
   input  logic       pop,
   output logic [1:0] count,
   output T           head
);

   T     mem [2];
   logic wr_ptr;
   logic rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch stage: buffers decoded instructions, steers the head to a reservation station
// and allocates ROB/free-list resources. Optional perf counters under DISPATCH_PERF_EN.
module dispatch_ctrl
   import dispatch_ctrl_pkg::*;
#(
   parameter int N_RS   = 3,
   parameter int PREG_W = 7,
   parameter int ROB_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              valid_in,
   output logic              ready_in,
   input  decode_data        data_in,
   output logic [N_RS-1:0]   rs_valid,
   input  logic [N_RS-1:0]   rs_ready,
   output decode_data        rs_data,
   output logic              rob_alloc,
   input  logic              rob_ready,
   input  logic [ROB_W-1:0]  rob_tag,
   output logic [ROB_W-1:0]  disp_rob_tag,
   output logic              fl_pop,
   input  logic              fl_empty,
   input  logic [PREG_W-1:0] fl_preg,
   output logic [PREG_W-1:0] disp_prd
`ifdef DISPATCH_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_dispatched
`endif
);

   logic [1:0]  fifo_count;
   decode_data  head;
   logic        head_v;
   logic        accept;
   logic        fire;
   logic        needs_rd;
   logic        rs_sel_ready;

   skid_fifo2 #(.T(decode_data)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (accept),
      .push_data (data_in),
      .pop       (fire),
      .count     (fifo_count),
      .head      (head)
   );

   assign ready_in = (fifo_count != 2'd2);
   assign accept   = valid_in && ready_in && !flush;
   assign head_v   = (fifo_count != 2'd0);
   assign needs_rd = writes_rd(head);

   // An out-of-range fu selects no RS, so it never fires.
   always_comb begin
      rs_sel_ready = 1'b0;
      for (int i = 0; i < N_RS; i++) begin
         if (int'(head.fu) == i) rs_sel_ready = rs_ready[i];
      end
   end

   assign fire = head_v && !flush && rs_sel_ready && rob_ready && (!needs_rd || !fl_empty);

   always_comb begin
      rs_valid = '0;
      for (int i = 0; i < N_RS; i++) begin
         rs_valid[i] = fire && (int'(head.fu) == i);
      end
   end

   assign rob_alloc    = fire;
   assign fl_pop       = fire && needs_rd;
   assign rs_data      = head;
   assign disp_rob_tag = rob_tag;
   assign disp_prd     = needs_rd ? fl_preg : '0;

`ifdef DISPATCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cycles <= 32'd0;
         perf_dispatched   <= 32'd0;
      end else begin
         if (fire)                      perf_dispatched   <= perf_dispatched + 32'd1;
         if (head_v && !fire && !flush) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: per-cycle vector table plus hand sequences for
// flush at full occupancy and async reset during a stall.
module tb_dispatch_ctrl;
   import dispatch_ctrl_pkg::*;

   localparam logic [6:0] OP_ALU  = 7'b0110011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;

   logic       clk;
   logic       reset;
   logic       flush;
   logic       valid_in;
   logic       ready_in;
   decode_data data_in;
   logic [2:0] rs_valid;
   logic [2:0] rs_ready;
   decode_data rs_data;
   logic       rob_alloc;
   logic       rob_ready;
   logic [4:0] rob_tag;
   logic [4:0] disp_rob_tag;
   logic       fl_pop;
   logic       fl_empty;
   logic [6:0] fl_preg;
   logic [6:0] disp_prd;
`ifdef DISPATCH_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_dispatched;
`endif

   dispatch_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .valid_in     (valid_in),
      .ready_in     (ready_in),
      .data_in      (data_in),
      .rs_valid     (rs_valid),
      .rs_ready     (rs_ready),
      .rs_data      (rs_data),
      .rob_alloc    (rob_alloc),
      .rob_ready    (rob_ready),
      .rob_tag      (rob_tag),
      .disp_rob_tag (disp_rob_tag),
      .fl_pop       (fl_pop),
      .fl_empty     (fl_empty),
      .fl_preg      (fl_preg),
      .disp_prd     (disp_prd)
`ifdef DISPATCH_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_dispatched   (perf_dispatched)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       vi;
      decode_data d;
      logic [2:0] rsr;
      logic       robr;
      logic       fle;
      logic       e_rdy;
      logic [2:0] e_rsv;
      logic       e_pop;
      logic [4:0] e_rd;
   } vec_t;

   vec_t vt [32];
   int   n_vec = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic decode_data ins(input logic [6:0] op, input logic [4:0] rd, input logic [1:0] fu);
      decode_data d;
      d.opcode = op;
      d.rd     = rd;
      d.rs1    = 5'd1;
      d.rs2    = 5'd2;
      d.fu     = fu;
      d.imm    = {7'd0, rd};
      return d;
   endfunction

   task automatic add(input logic vi, input decode_data d, input logic [2:0] rsr, input logic robr,
                      input logic fle, input logic e_rdy, input logic [2:0] e_rsv, input logic e_pop,
                      input logic [4:0] e_rd);
      vt[n_vec] = '{vi, d, rsr, robr, fle, e_rdy, e_rsv, e_pop, e_rd};
      n_vec++;
   endtask

   task automatic drive(input logic vi, input decode_data d, input logic [2:0] rsr, input logic robr,
                        input logic fle, input logic fl);
      valid_in = vi;
      data_in  = d;
      rs_ready = rsr;
      rob_ready = robr;
      fl_empty = fle;
      flush    = fl;
   endtask

   // Steering to a non-existent RS would deadlock the FIFO; it must never be at the head.
   always @(negedge clk) begin
      if (!reset && dut.head_v && rs_data.fu >= 2'd3) begin
         errors++;
         $display("FAIL fu_range actual=%0d required=<3", rs_data.fu);
      end
   end

   initial begin
      decode_data idle;
      idle = ins(OP_ALU, 5'd0, FU_ALU);

      // back-to-back ALU, all resources ready
      add(1, ins(OP_ALU, 5'd5, FU_ALU), 3'b111, 1, 0,  1, 3'b000, 0, 5'd0);
      add(1, ins(OP_ALU, 5'd6, FU_ALU), 3'b111, 1, 0,  1, 3'b001, 1, 5'd5);
      add(1, ins(OP_ALU, 5'd7, FU_ALU), 3'b111, 1, 0,  1, 3'b001, 1, 5'd6);
      add(0, idle,                      3'b111, 1, 0,  1, 3'b001, 1, 5'd7);
      add(0, idle,                      3'b111, 1, 0,  1, 3'b000, 0, 5'd0);
      // ROB full: fill to 2, hold C, then drain in order
      add(1, ins(OP_ALU, 5'd8, FU_ALU),  3'b111, 0, 0, 1, 3'b000, 0, 5'd0);
      add(1, ins(OP_ALU, 5'd9, FU_ALU),  3'b111, 0, 0, 1, 3'b000, 0, 5'd0);
      add(1, ins(OP_ALU, 5'd10, FU_ALU), 3'b111, 0, 0, 0, 3'b000, 0, 5'd0);
      add(1, ins(OP_ALU, 5'd10, FU_ALU), 3'b111, 0, 0, 0, 3'b000, 0, 5'd0);
      add(1, ins(OP_ALU, 5'd10, FU_ALU), 3'b111, 1, 0, 0, 3'b001, 1, 5'd8);
      add(1, ins(OP_ALU, 5'd10, FU_ALU), 3'b111, 1, 0, 1, 3'b001, 1, 5'd9);
      add(0, idle,                       3'b111, 1, 0, 1, 3'b001, 1, 5'd10);
      add(0, idle,                       3'b111, 1, 0, 1, 3'b000, 0, 5'd0);
      // store with empty free list
      add(1, ins(OP_STORE, 5'd3, FU_LSU), 3'b111, 1, 1, 1, 3'b000, 0, 5'd0);
      add(0, idle,                        3'b111, 1, 1, 1, 3'b100, 0, 5'd3);
      // rd=0 ALU with empty free list
      add(1, ins(OP_ALU, 5'd0, FU_ALU), 3'b111, 1, 1, 1, 3'b000, 0, 5'd0);
      add(0, idle,                      3'b111, 1, 1, 1, 3'b001, 0, 5'd0);
      // ALU needing a preg waits for the free list
      add(1, ins(OP_ALU, 5'd4, FU_ALU), 3'b111, 1, 1, 1, 3'b000, 0, 5'd0);
      add(0, idle,                      3'b111, 1, 1, 1, 3'b000, 0, 5'd0);
      add(0, idle,                      3'b111, 1, 0, 1, 3'b001, 1, 5'd4);
      // branch with nonzero rd never pops
      add(1, ins(OP_BRANCH, 5'd2, FU_BRANCH), 3'b111, 1, 1, 1, 3'b000, 0, 5'd0);
      add(0, idle,                            3'b111, 1, 1, 1, 3'b010, 0, 5'd2);
      // load waits for its own RS only
      add(1, ins(OP_LOAD, 5'd11, FU_LSU), 3'b011, 1, 0, 1, 3'b000, 0, 5'd0);
      add(0, idle,                        3'b011, 1, 0, 1, 3'b000, 0, 5'd0);
      add(0, idle,                        3'b100, 1, 0, 1, 3'b100, 1, 5'd11);
      add(0, idle,                        3'b111, 1, 0, 1, 3'b000, 0, 5'd0);

      reset   = 1'b1;
      rob_tag = 5'd0;
      fl_preg = 7'd0;
      drive(0, idle, 3'b111, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #4;
      chk("reset_ready_in", 32'(ready_in), 32'd1);
      chk("reset_rob_alloc", 32'(rob_alloc), 32'd0);
      chk("reset_rs_valid", 32'(rs_valid), 32'd0);
`ifdef DISPATCH_PERF_EN
      chk("reset_perf_disp", perf_dispatched, 32'd0);
      chk("reset_perf_stall", perf_stall_cycles, 32'd0);
`endif

      for (int i = 0; i < n_vec; i++) begin
         @(posedge clk);
         #1;
         drive(vt[i].vi, vt[i].d, vt[i].rsr, vt[i].robr, vt[i].fle, 0);
         fl_preg = 7'h40 + 7'(i);
         rob_tag = 5'(i);
         #4;
         chk($sformatf("v%0d_ready_in", i), 32'(ready_in), 32'(vt[i].e_rdy));
         chk($sformatf("v%0d_rs_valid", i), 32'(rs_valid), 32'(vt[i].e_rsv));
         chk($sformatf("v%0d_rob_alloc", i), 32'(rob_alloc), 32'(|vt[i].e_rsv));
         chk($sformatf("v%0d_fl_pop", i), 32'(fl_pop), 32'(vt[i].e_pop));
         if (|vt[i].e_rsv) begin
            chk($sformatf("v%0d_disp_prd", i), 32'(disp_prd), vt[i].e_pop ? 32'(7'h40 + 7'(i)) : 32'd0);
            chk($sformatf("v%0d_head_rd", i), 32'(rs_data.rd), 32'(vt[i].e_rd));
            chk($sformatf("v%0d_rob_tag", i), 32'(disp_rob_tag), 32'(i));
         end
      end
`ifdef DISPATCH_PERF_EN
      chk("perf_dispatched", perf_dispatched, 32'd11);
      chk("perf_stall_cycles", perf_stall_cycles, 32'd5);
`endif

      // flush at count 2 together with a valid input
      @(posedge clk); #1 drive(1, ins(OP_ALU, 5'd12, FU_ALU), 3'b111, 0, 0, 0);
      @(posedge clk); #1 drive(1, ins(OP_ALU, 5'd13, FU_ALU), 3'b111, 0, 0, 0);
      @(posedge clk); #1 drive(1, ins(OP_ALU, 5'd14, FU_ALU), 3'b111, 1, 0, 1);
      #4;
      chk("flush_cyc_ready_in", 32'(ready_in), 32'd0);
      chk("flush_cyc_rs_valid", 32'(rs_valid), 32'd0);
      chk("flush_cyc_rob_alloc", 32'(rob_alloc), 32'd0);
      chk("flush_cyc_fl_pop", 32'(fl_pop), 32'd0);
      @(posedge clk); #1 drive(0, idle, 3'b111, 1, 0, 0);
      #4;
      chk("post_flush_ready_in", 32'(ready_in), 32'd1);
      chk("post_flush_rob_alloc", 32'(rob_alloc), 32'd0);
      @(posedge clk); #1 drive(1, ins(OP_ALU, 5'd15, FU_ALU), 3'b111, 1, 0, 0);
      #4;
      chk("post_flush_empty", 32'(rob_alloc), 32'd0);
      @(posedge clk); #1 drive(0, idle, 3'b111, 1, 0, 0);
      #4;
      chk("post_flush_fire", 32'(rob_alloc), 32'd1);
      chk("post_flush_head_rd", 32'(rs_data.rd), 32'd15);
      chk("post_flush_rs_valid", 32'(rs_valid), 32'b001);
      @(posedge clk); #1;
      #4;
      chk("post_flush_drained", 32'(rob_alloc), 32'd0);

      // async reset during a stall at count 2
      @(posedge clk); #1 drive(1, ins(OP_ALU, 5'd16, FU_ALU), 3'b111, 0, 0, 0);
      @(posedge clk); #1 drive(1, ins(OP_ALU, 5'd17, FU_ALU), 3'b111, 0, 0, 0);
      @(posedge clk); #1 drive(0, idle, 3'b111, 0, 0, 0);
      #4;
      chk("stall_ready_in", 32'(ready_in), 32'd0);
      chk("stall_rob_alloc", 32'(rob_alloc), 32'd0);
      #1 rob_ready = 1'b1;
      #1;
      chk("pre_reset_rob_alloc", 32'(rob_alloc), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_reset_rs_valid", 32'(rs_valid), 32'd0);
      chk("async_reset_rob_alloc", 32'(rob_alloc), 32'd0);
      chk("async_reset_fl_pop", 32'(fl_pop), 32'd0);
      chk("async_reset_ready_in", 32'(ready_in), 32'd1);
`ifdef DISPATCH_PERF_EN
      chk("async_reset_perf_disp", perf_dispatched, 32'd0);
      chk("async_reset_perf_stall", perf_stall_cycles, 32'd0);
`endif
      @(posedge clk); #1 reset = 1'b0;
      #4;
      chk("after_reset_ready_in", 32'(ready_in), 32'd1);
      chk("after_reset_rob_alloc", 32'(rob_alloc), 32'd0);
      @(posedge clk); #1 drive(1, ins(OP_ALU, 5'd18, FU_ALU), 3'b111, 1, 0, 0);
      @(posedge clk); #1 drive(0, idle, 3'b111, 1, 0, 0);
      #4;
      chk("after_reset_fire", 32'(rob_alloc), 32'd1);
      chk("after_reset_head_rd", 32'(rs_data.rd), 32'd18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
